pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage 16-bit RISC pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage 16-bit RISC pipeline.
// Tracks EX/MEM/WB destinations to drive stalls, flushes, PC select and operand bypass.
module pipeline_hazard_ctrl #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] dest;
        logic            reg_write;
        logic            mem_read;
    } shadow_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    shadow_t         ex_q, ex_d, mem_q, wb_q;
    logic [RA_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic            ex_use_rs1_q, ex_use_rs1_d, ex_use_rs2_q, ex_use_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic            load_use_s, stall_evt_s, flush_evt_s;

    assign load_use_s = ex_q.valid & ex_q.mem_read & ex_q.reg_write & id_valid &
                        ((id_use_rs1 & (id_rs1 == ex_q.dest)) |
                         (id_use_rs2 & (id_rs2 == ex_q.dest)));

    // Pipeline sequencing: redirect beats load-use stall, which beats a jump in ID.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_sel      = 2'b00;
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hold) begin
            pc_en = 1'b0;
        end else if (ex_redirect) begin
            pc_sel      = 2'b10;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            flush_evt_s = 1'b1;
        end else if (load_use_s) begin
            idex_flush  = 1'b1;
            stall_evt_s = 1'b1;
        end else if (id_jump && id_valid) begin
            pc_sel      = 2'b01;
            ifid_flush  = 1'b1;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            flush_evt_s = 1'b1;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
        end
    end

    // Next EX shadow: either a bubble or the instruction currently in ID.
    always_comb begin
        ex_d         = '0;
        ex_rs1_d     = '0;
        ex_rs2_d     = '0;
        ex_use_rs1_d = 1'b0;
        ex_use_rs2_d = 1'b0;
        if (idex_flush) begin
            ex_d.valid = 1'b0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.dest      = id_dest;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_use_rs1_d   = id_use_rs1;
            ex_use_rs2_d   = id_use_rs2;
        end
    end

    // Shadow stage registers advance together unless the pipeline is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_use_rs1_q <= 1'b0;
            ex_use_rs2_q <= 1'b0;
        end else if (!hold) begin
            ex_q         <= ex_d;
            mem_q        <= ex_q;
            wb_q         <= mem_q;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_use_rs1_q <= ex_use_rs1_d;
            ex_use_rs2_q <= ex_use_rs2_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_evt_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // A load sitting in MEM has no data yet, so only non-load results forward from EX/MEM.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        id_byp_a  = 1'b0;
        id_byp_b  = 1'b0;
        if (rst) begin
            fwd_a_sel = 2'b00;
        end else begin
            if (mem_q.valid && mem_q.reg_write && !mem_q.mem_read &&
                (mem_q.dest == ex_rs1_q) && ex_use_rs1_q) begin
                fwd_a_sel = 2'b10;
            end else if (wb_q.valid && wb_q.reg_write &&
                         (wb_q.dest == ex_rs1_q) && ex_use_rs1_q) begin
                fwd_a_sel = 2'b01;
            end else begin
                fwd_a_sel = 2'b00;
            end
            if (mem_q.valid && mem_q.reg_write && !mem_q.mem_read &&
                (mem_q.dest == ex_rs2_q) && ex_use_rs2_q) begin
                fwd_b_sel = 2'b10;
            end else if (wb_q.valid && wb_q.reg_write &&
                         (wb_q.dest == ex_rs2_q) && ex_use_rs2_q) begin
                fwd_b_sel = 2'b01;
            end else begin
                fwd_b_sel = 2'b00;
            end
            id_byp_a = wb_q.valid & wb_q.reg_write & id_valid & id_use_rs1 & (wb_q.dest == id_rs1);
            id_byp_b = wb_q.valid & wb_q.reg_write & id_valid & id_use_rs2 & (wb_q.dest == id_rs2);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; a second instance with CNT_W=2
// exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, hold, id_valid, id_use_rs1, id_use_rs2;
    logic        id_reg_write, id_mem_read, id_jump, ex_redirect;
    logic [2:0]  id_rs1, id_rs2, id_dest;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, id_byp_a, id_byp_b;
    logic [1:0]  pc_sel, fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_byp_a, s_byp_b;
    logic [1:0]  s_pc_sel, s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.RA_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_jump(id_jump), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pc_sel(pc_sel), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.RA_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_jump(id_jump), .ex_redirect(ex_redirect),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .pc_sel(s_pc_sel), .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .id_byp_a(s_byp_a), .id_byp_b(s_byp_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic set_id(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                          input logic u1, input logic u2, input logic [2:0] d,
                          input logic rw, input logic mr, input logic j);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_dest = d; id_reg_write = rw; id_mem_read = mr; id_jump = j;
    endtask

    task automatic nop();
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nop();
        hold = 1'b0;
        ex_redirect = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; ex_redirect = 1'b0;
        nop();
        repeat (2) tick();
        checks++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0011) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0011", {pc_en, ifid_en, ifid_flush, idex_flush});
        end
        checks++;
        if ({pc_sel, fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b} !== 8'h00) begin
            errors++; $display("FAIL reset_sel: got %h want 00", {pc_sel, fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b});
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
            errors++; $display("FAIL post_reset: pc_en=%b idex_flush=%b want 1/0", pc_en, idex_flush);
        end
    endtask

    task automatic test_forward();
        idle();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);  // ADD r1,r2,r3
        tick();
        set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);  // ADD r2,r1,r3
        #1;
        checks++;
        if (pc_en !== 1'b1 || fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL fwd_pre: pc_en=%b fwd_a=%b want 1/00", pc_en, fwd_a_sel);
        end
        tick();
        nop(); #1;
        checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL fwd_exmem: a=%b b=%b want 10/00", fwd_a_sel, fwd_b_sel);
        end
        idle();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        nop(); #1;
        checks++;
        if (fwd_a_sel !== 2'b01) begin
            errors++; $display("FAIL fwd_memwb: a=%b want 01", fwd_a_sel);
        end
        idle();
        // Two writers of r1 back to back: the younger (EX/MEM) must win on operand B.
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3'd4, 3'd5, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        nop(); #1;
        checks++;
        if (fwd_b_sel !== 2'b10 || fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL fwd_priority: a=%b b=%b want 00/10", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        idle();
        set_id(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);  // LW r2
        tick();
        set_id(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);  // SUB r4,r2,r1
        #1;
        checks++;
        if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0001) begin
            errors++; $display("FAIL lu_stall: got %b want 0001", {pc_en, ifid_en, ifid_flush, idex_flush});
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
        end
        checks++;
        if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
            errors++; $display("FAIL lu_release: pc_en=%b idex_flush=%b want 1/0", pc_en, idex_flush);
        end
        tick();
        nop(); #1;
        checks++;
        if (fwd_a_sel !== 2'b01) begin
            errors++; $display("FAIL lu_fwd: a=%b want 01", fwd_a_sel);
        end
    endtask

    task automatic test_redirect();
        idle();
        set_id(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);  // load-use plus jump flag
        ex_redirect = 1'b1;
        #1;
        checks++;
        if ({pc_sel, pc_en, ifid_en, ifid_flush, idex_flush} !== 6'b101111) begin
            errors++; $display("FAIL redirect: got %b want 101111", {pc_sel, pc_en, ifid_en, ifid_flush, idex_flush});
        end
        tick();
        ex_redirect = 1'b0;
        nop(); #1;
        checks++;
        if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL redirect_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_jump();
        idle();
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);  // J
        #1;
        checks++;
        if ({pc_sel, pc_en, ifid_flush, idex_flush} !== 5'b01110) begin
            errors++; $display("FAIL jump: got %b want 01110", {pc_sel, pc_en, ifid_flush, idex_flush});
        end
        tick();
        nop(); #1;
        checks++;
        if (flush_cnt !== 16'd2 || ifid_flush !== 1'b0 || pc_sel !== 2'b00) begin
            errors++; $display("FAIL jump_after: cnt=%0d flush=%b sel=%b want 2/0/00", flush_cnt, ifid_flush, pc_sel);
        end
        set_id(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);  // J reading r2 behind LW r2
        #1;
        checks++;
        if ({pc_sel, pc_en, ifid_flush, idex_flush} !== 5'b00001) begin
            errors++; $display("FAIL jump_wait: got %b want 00001", {pc_sel, pc_en, ifid_flush, idex_flush});
        end
        tick();
        checks++;
        if (pc_sel !== 2'b01 || ifid_flush !== 1'b1 || stall_cnt !== 16'd2 || flush_cnt !== 16'd2) begin
            errors++; $display("FAIL jump_go: sel=%b flush=%b cnt=%0d/%0d want 01/1/2/2", pc_sel, ifid_flush, stall_cnt, flush_cnt);
        end
        tick();
        checks++;
        if (flush_cnt !== 16'd3) begin
            errors++; $display("FAIL jump_cnt: got %0d want 3", flush_cnt);
        end
    endtask

    task automatic test_hold();
        idle();
        set_id(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0000) begin
                errors++; $display("FAIL hold_%0d: got %b want 0000", i, {pc_en, ifid_en, ifid_flush, idex_flush});
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++; $display("FAIL hold_cnt: got %0d want 2", stall_cnt);
        end
        hold = 1'b0; #1;
        checks++;
        if (pc_en !== 1'b0 || idex_flush !== 1'b1) begin
            errors++; $display("FAIL hold_release: pc_en=%b idex_flush=%b want 0/1", pc_en, idex_flush);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++; $display("FAIL hold_stall_cnt: got %0d want 3", stall_cnt);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);  // ADD r5
        tick();
        nop(); tick(); tick();
        set_id(1'b1, 3'd5, 3'd5, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (id_byp_a !== 1'b1 || id_byp_b !== 1'b0) begin
            errors++; $display("FAIL byp_a: a=%b b=%b want 1/0", id_byp_a, id_byp_b);
        end
        id_use_rs2 = 1'b1; id_rs1 = 3'd4;
        #1;
        checks++;
        if (id_byp_a !== 1'b0 || id_byp_b !== 1'b1) begin
            errors++; $display("FAIL byp_b: a=%b b=%b want 0/1", id_byp_a, id_byp_b);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        idle();
        set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        nop(); #1;
        checks++;
        if (fwd_a_sel !== 2'b10) begin
            errors++; $display("FAIL rst_pre: a=%b want 10", fwd_a_sel);
        end
        rst = 1'b1; #1;
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || idex_flush !== 1'b1 || pc_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid: cnt=%0d/%0d idex_flush=%b pc_en=%b want 0/0/1/0", stall_cnt, flush_cnt, idex_flush, pc_en);
        end
        rst = 1'b0; #1;
        checks++;
        if (fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL rst_clear: a=%b want 00", fwd_a_sel);
        end
    endtask

    task automatic test_saturate();
        idle();
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (s_stall_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_cnt2: got %0d want 3", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++; $display("FAIL sat_cnt16: got %0d want 5", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_jump();
        test_hold();
        test_bypass();
        test_rst_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
